cr_zigzag_rle: RTL and testbench
================================

CR_ZIGZAG_RLE -- requirements
Module: cr_zigzag_rle

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 11, giving the width of a signed quantized coefficient.
REQ-002 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, high when q_block holds a valid quantized 8x8 Cr block.
REQ-005 SHALL have port in_ready, output, 1, high when the block can accept a new q_block.
REQ-006 SHALL have port q_block, input, [8][8] x INPUT_WIDTH, signed coefficients indexed [row][col].
REQ-007 SHALL have port dc_clear, input, 1, a one-cycle pulse that clears the DC predictor.
REQ-008 SHALL have port sym_valid, output, 1, high when a symbol is presented.
REQ-009 SHALL have port sym_ready, input, 1, downstream accept.
REQ-010 SHALL have port sym_run, output, 4, zero-run length.
REQ-011 SHALL have port sym_size, output, 4, magnitude category.
REQ-012 SHALL have port sym_amp, output, INPUT_WIDTH, amplitude bits; only the low sym_size bits are meaningful and all other bits are 0.
REQ-013 SHALL have port sym_is_dc, output, 1, high when the current symbol is the DC symbol.
REQ-014 SHALL have port sym_last, output, 1, high when the current symbol is the final symbol of the block.

Function
REQ-015 SHALL implement the FSM states IDLE, DC, AC and LAST.
REQ-016 in_ready SHALL be 1 only in IDLE; q_block SHALL be captured into an internal 64-entry buffer when in_valid && in_ready, and the FSM SHALL then move to DC.
REQ-017 In DC, the symbol SHALL be computed as follows:
- diff = q[0][0] - prev_dc, using INPUT_WIDTH+1-bit signed arithmetic.
- prev_dc SHALL be updated to q[0][0].
- sym_run = 0 and sym_is_dc = 1.
- sym_valid SHALL be high on the cycle after capture (latency 1).
REQ-018 size SHALL be the bit length of |value|, with 0 giving 0; amp SHALL be value if value > 0, else (value-1) masked to size bits.
REQ-019 AC SHALL scan zigzag indices 1..63 in standard JPEG zigzag order (0,1,8,16,9,2,3,10,17,24,...,63 as row*8+col), one index per cycle when not stalled.
REQ-020 Zero coefficients SHALL increment a 6-bit run counter and emit no symbol.
REQ-021 On a nonzero coefficient with run>=16, the block SHALL emit ZRL (run=15, size=0, amp=0) and subtract 16, repeating until run<16; it SHALL then emit (run, size, amp) and reset run to 0.
REQ-022 ZRLs pending when the scan ends SHALL be discarded.
REQ-023 If index 63 is zero, the block SHALL emit EOB (run=0, size=0, amp=0) with sym_last=1.
REQ-024 If index 63 is nonzero, its symbol SHALL carry sym_last=1 and no EOB SHALL be emitted.
REQ-025 Symbol outputs SHALL remain stable while sym_valid && !sym_ready; the scan SHALL advance only on handshake or on zero-skip cycles.
REQ-026 After the sym_last handshake, the FSM SHALL return to IDLE, with in_ready=1 on the next cycle.
REQ-027 When sym_valid is 0, sym_run, sym_size, sym_amp, sym_is_dc and sym_last SHALL be 0.
REQ-028 dc_clear SHALL set prev_dc to 0 in any state; if it coincides with capture, the captured block SHALL use prev_dc=0.
REQ-029 A single DC diff of up to 2047 in magnitude SHALL yield size 11, and the amplitude SHALL fit INPUT_WIDTH bits.

Reset
REQ-030 While rst is high, the block SHALL hold: state=IDLE, in_ready=0, sym_* outputs=0, prev_dc=0, run=0, buffer=0.
REQ-031 in_ready SHALL be 1 on the first clock edge after rst deasserts.
REQ-032 Reset mid-block SHALL abort the block with no further symbols.

Verification
REQ-033 All-zero block with prev_dc=0 -> DC(run 0, size 0, amp 0, is_dc=1), then EOB with sym_last=1; exactly 2 symbols.
REQ-034 Block with DC=5, then block with DC=3 -> DC size 3 amp 101b; then diff -2 gives size 2 amp 01b.
REQ-035 DC=0 and only zigzag index 20 = 1 -> DC(0,0), ZRL(15,0), (run 3, size 1, amp 1), EOB with sym_last=1.
REQ-036 Only zigzag index 63 = -1 -> DC(0,0), ZRL x3, (run 14, size 1, amp 0) with sym_last=1, no EOB.
REQ-037 Hold sym_ready=0 for 5 cycles on an AC symbol -> all sym_* outputs stable and no index skipped; in_ready=0 throughout.
REQ-038 Assert rst during the AC scan, then release -> sym_valid=0 immediately and in_ready=1 after release; the next block's DC diff uses prev_dc=0.

Source files
------------

// File: rtl/cr_zigzag_rle.sv
// Zigzag scan and run-length coder for one quantized 8x8 Cr block.
// It emits a DC difference symbol, then AC (run, size, amp) symbols, and ends with EOB or the final coefficient.
module cr_zigzag_rle #(
    parameter int INPUT_WIDTH = 11
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [7:0][7:0][INPUT_WIDTH-1:0]      q_block,
    input  logic                                  dc_clear,
    output logic                                  sym_valid,
    input  logic                                  sym_ready,
    output logic [3:0]                            sym_run,
    output logic [3:0]                            sym_size,
    output logic [INPUT_WIDTH-1:0]                sym_amp,
    output logic                                  sym_is_dc,
    output logic                                  sym_last
);

    localparam int DW = INPUT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, DC, AC, LAST} state_t;

    typedef struct packed {
        logic                   valid;
        logic [3:0]             run;
        logic [3:0]             size;
        logic [INPUT_WIDTH-1:0] amp;
        logic                   is_dc;
        logic                   last;
    } sym_t;

    state_t                             state_q, state_d;
    logic [7:0][7:0][INPUT_WIDTH-1:0]   buf_q, buf_d;
    logic [INPUT_WIDTH-1:0]             prev_dc_q, prev_dc_d;
    logic [5:0]                         run_q, run_d;
    logic [2:0]                         row_q, row_d, col_q, col_d;
    logic                               alive_q;
    sym_t                               sym_q, sym_d;

    logic                               capture;
    logic                               load_ok;
    logic                               at_end;
    logic signed [DW-1:0]               dc_diff;
    logic signed [DW-1:0]               ac_val;
    logic [2:0]                         next_row, next_col;

    function automatic logic [3:0] mag_size(input logic signed [DW-1:0] v);
        logic [DW-1:0] mag;
        logic [3:0]    s;
        mag = v[DW-1] ? DW'(-v) : DW'(v);
        s   = '0;
        for (int i = 0; i < DW; i++) begin
            if (mag[i]) s = 4'(i + 1);
        end
        return s;
    endfunction

    // Negative values use the ones'-complement form (value - 1), truncated to size bits.
    function automatic logic [INPUT_WIDTH-1:0] amp_bits(input logic signed [DW-1:0] v,
                                                        input logic [3:0]           size);
        logic [DW-1:0] raw;
        logic [DW-1:0] mask;
        raw  = v[DW-1] ? DW'(v - DW'(1)) : DW'(v);
        mask = (DW'(1) << size) - DW'(1);
        return INPUT_WIDTH'(raw & mask);
    endfunction

    assign capture  = in_valid && in_ready;
    assign in_ready = (state_q == IDLE) && alive_q;
    assign load_ok  = !sym_q.valid || sym_ready;
    assign at_end   = (row_q == 3'd7) && (col_q == 3'd7);
    assign ac_val   = $signed({buf_q[row_q][col_q][INPUT_WIDTH-1], buf_q[row_q][col_q]});
    assign dc_diff  = $signed({q_block[0][0][INPUT_WIDTH-1], q_block[0][0]})
                    - (dc_clear ? DW'(0) : $signed({prev_dc_q[INPUT_WIDTH-1], prev_dc_q}));

    // Zigzag walker: even diagonals move up-right, odd diagonals move down-left.
    always_comb begin
        next_row = row_q;
        next_col = col_q;
        if ((row_q[0] ^ col_q[0]) == 1'b0) begin
            if (col_q == 3'd7) begin
                next_row = row_q + 3'd1;
            end else if (row_q == 3'd0) begin
                next_col = col_q + 3'd1;
            end else begin
                next_row = row_q - 3'd1;
                next_col = col_q + 3'd1;
            end
        end else begin
            if (row_q == 3'd7) begin
                next_col = col_q + 3'd1;
            end else if (col_q == 3'd0) begin
                next_row = row_q + 3'd1;
            end else begin
                next_row = row_q + 3'd1;
                next_col = col_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        prev_dc_d = prev_dc_q;
        run_d     = run_q;
        row_d     = row_q;
        col_d     = col_q;
        sym_d     = sym_q;

        if (dc_clear) prev_dc_d = '0;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    buf_d       = q_block;
                    prev_dc_d   = q_block[0][0];
                    sym_d       = '0;
                    sym_d.valid = 1'b1;
                    sym_d.size  = mag_size(dc_diff);
                    sym_d.amp   = amp_bits(dc_diff, mag_size(dc_diff));
                    sym_d.is_dc = 1'b1;
                    run_d       = '0;
                    row_d       = 3'd0;
                    col_d       = 3'd1;
                    state_d     = DC;
                end
            end
            DC: begin
                if (sym_ready) begin
                    sym_d   = '0;
                    state_d = AC;
                end
            end
            AC: begin
                if (load_ok) begin
                    sym_d = '0;
                    if (ac_val == '0) begin
                        // A run still pending at the last index is dropped in favour of EOB.
                        if (at_end) begin
                            sym_d.valid = 1'b1;
                            sym_d.last  = 1'b1;
                            state_d     = LAST;
                        end else begin
                            run_d = run_q + 6'd1;
                            row_d = next_row;
                            col_d = next_col;
                        end
                    end else if (run_q >= 6'd16) begin
                        sym_d.valid = 1'b1;
                        sym_d.run   = 4'd15;
                        run_d       = run_q - 6'd16;
                    end else begin
                        sym_d.valid = 1'b1;
                        sym_d.run   = run_q[3:0];
                        sym_d.size  = mag_size(ac_val);
                        sym_d.amp   = amp_bits(ac_val, mag_size(ac_val));
                        sym_d.last  = at_end;
                        run_d       = '0;
                        if (at_end) begin
                            state_d = LAST;
                        end else begin
                            row_d = next_row;
                            col_d = next_col;
                        end
                    end
                end
            end
            LAST: begin
                if (sym_ready) begin
                    sym_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            prev_dc_q <= '0;
            run_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            alive_q   <= 1'b0;
            sym_q     <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            prev_dc_q <= prev_dc_d;
            run_q     <= run_d;
            row_q     <= row_d;
            col_q     <= col_d;
            alive_q   <= 1'b1;
            sym_q     <= sym_d;
        end
    end

    assign sym_valid = sym_q.valid;
    assign sym_run   = sym_q.run;
    assign sym_size  = sym_q.size;
    assign sym_amp   = sym_q.amp;
    assign sym_is_dc = sym_q.is_dc;
    assign sym_last  = sym_q.last;

endmodule

// File: tb/tb_cr_zigzag_rle.sv
// Bench for cr_zigzag_rle: directed and random blocks checked against a symbol-list model.
module tb_cr_zigzag_rle;

    localparam int IW = 11;

    typedef logic [7:0][7:0][IW-1:0] blk_t;
    typedef logic [20:0] sym_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    blk_t          q_block = '0;
    logic          dc_clear = 1'b0;
    logic          sym_valid;
    logic          sym_ready = 1'b0;
    logic [3:0]    sym_run;
    logic [3:0]    sym_size;
    logic [IW-1:0] sym_amp;
    logic          sym_is_dc;
    logic          sym_last;

    int   vectors = 0;
    int   miscompares = 0;
    int   prev_dc = 0;
    int   zz_row[64];
    int   zz_col[64];
    sym_t exp_q[$];

    cr_zigzag_rle #(.INPUT_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .q_block(q_block), .dc_clear(dc_clear), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .sym_run(sym_run), .sym_size(sym_size),
        .sym_amp(sym_amp), .sym_is_dc(sym_is_dc), .sym_last(sym_last)
    );

    always #5 clk = ~clk;

    function automatic sym_t mk(input int run, input int size, input int amp, input bit dc, input bit last);
        logic [3:0]    r;
        logic [3:0]    s;
        logic [IW-1:0] a;
        r = 4'(run);
        s = 4'(size);
        a = IW'(amp);
        return {r, s, a, dc, last};
    endfunction

    function automatic sym_t cur();
        return {sym_run, sym_size, sym_amp, sym_is_dc, sym_last};
    endfunction

    function automatic int size_of(input int v);
        int m;
        int s;
        m = (v < 0) ? -v : v;
        s = 0;
        while (m > 0) begin
            s++;
            m = m >> 1;
        end
        return s;
    endfunction

    function automatic int amp_of(input int v);
        int s;
        s = size_of(v);
        if (v > 0) return v;
        return (v - 1) & ((1 << s) - 1);
    endfunction

    // Diagonal s holds all (row, col) with row+col = s; even diagonals are walked bottom-up.
    function automatic void build_zigzag();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_row[k] = r; zz_col[k] = s - r; k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_row[k] = r; zz_col[k] = s - r; k++;
                end
            end
        end
    endfunction

    function automatic void build_expected(input blk_t blk, input int prev);
        int diff;
        int run;
        int v;
        exp_q.delete();
        diff = int'($signed(blk[0][0])) - prev;
        exp_q.push_back(mk(0, size_of(diff), amp_of(diff), 1'b1, 1'b0));
        run = 0;
        for (int k = 1; k < 64; k++) begin
            v = int'($signed(blk[zz_row[k]][zz_col[k]]));
            if (v == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(mk(15, 0, 0, 1'b0, 1'b0));
                    run -= 16;
                end
                exp_q.push_back(mk(run, size_of(v), amp_of(v), 1'b0, k == 63));
                run = 0;
            end
        end
        if (blk[7][7] == '0) exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, then consume every symbol with random backpressure until sym_last.
    task automatic applyStimulus(input blk_t blk, input bit clr, input bit do_stall);
        int   cyc;
        int   idx;
        bit   done;
        bit   stalled;
        sym_t held;
        build_expected(blk, clr ? 0 : prev_dc);
        prev_dc  = int'($signed(blk[0][0]));
        q_block  = blk;
        in_valid = 1'b1;
        dc_clear = clr;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput("in_ready_at_capture", in_ready, 1);
        tick();
        in_valid = 1'b0;
        dc_clear = 1'b0;
        q_block  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        checkOutput("dc_latency", sym_valid, 1);
        idx = 0;
        done = 1'b0;
        stalled = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            sym_ready = ($urandom_range(0, 3) != 0);
            if (do_stall && !stalled && sym_valid && !sym_is_dc) begin
                stalled   = 1'b1;
                held      = cur();
                sym_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    cyc++;
                    checkOutput("stall_valid", sym_valid, 1);
                    checkOutput("stall_hold", cur(), held);
                    checkOutput("stall_in_ready", in_ready, 0);
                end
                sym_ready = 1'b1;
            end
            if (!sym_valid) begin
                checkOutput("idle_outputs_zero", cur(), 0);
            end else if (sym_ready) begin
                if (idx < exp_q.size()) checkOutput($sformatf("symbol_%0d", idx), cur(), exp_q[idx]);
                else checkOutput("extra_symbol", idx, exp_q.size());
                if (sym_last) done = 1'b1;
                idx++;
            end
            checkOutput("busy_in_ready", in_ready, 0);
            tick();
            cyc++;
        end
        sym_ready = 1'b0;
        checkOutput("block_finished", done, 1);
        checkOutput("symbol_count", idx, exp_q.size());
        checkOutput("in_ready_after_last", in_ready, 1);
    endtask

    function automatic blk_t random_block(input int density);
        blk_t b;
        int   v;
        b = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if ((r == 0 && c == 0) || $urandom_range(0, 99) < density) begin
                    v = int'($urandom_range(0, 2047)) - 1024;
                    if ($urandom_range(0, 1) == 1) v = v % 8;
                    b[r][c] = IW'(v);
                end
            end
        end
        return b;
    endfunction

    initial begin
        blk_t b;
        int   cyc;
        build_zigzag();

        // Reset: ready and symbol outputs stay low while rst is held.
        repeat (3) tick();
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_sym_valid", sym_valid, 0);
        checkOutput("reset_outputs", cur(), 0);
        rst = 1'b0;
        tick();
        checkOutput("ready_after_reset", in_ready, 1);

        // All-zero block: DC(0,0) then EOB.
        applyStimulus('0, 1'b0, 1'b0);

        // DC predictor: 5 then 3 (diff -2).
        b = '0; b[0][0] = IW'(5);
        applyStimulus(b, 1'b0, 1'b0);
        b = '0; b[0][0] = IW'(3);
        applyStimulus(b, 1'b0, 1'b0);

        // Only zigzag index 20 = 1, with dc_clear coinciding with capture.
        build_zigzag();
        b = '0; b[zz_row[20]][zz_col[20]] = IW'(1);
        applyStimulus(b, 1'b1, 1'b0);

        // Only index 63 = -1: three ZRLs and a final symbol with no EOB.
        b = '0; b[7][7] = IW'(-1);
        applyStimulus(b, 1'b0, 1'b0);

        // DC extremes: diffs -1024, +2047, -2047.
        b = '0; b[0][0] = IW'(-1024);
        applyStimulus(b, 1'b1, 1'b0);
        b = '0; b[0][0] = IW'(1023); b[0][1] = IW'(-1024);
        applyStimulus(b, 1'b0, 1'b0);
        b = '0; b[0][0] = IW'(-1024); b[7][7] = IW'(1023);
        applyStimulus(b, 1'b0, 1'b0);

        // Backpressure on an AC symbol.
        b = '0; b[0][1] = IW'(7); b[2][3] = IW'(-4); b[5][5] = IW'(2);
        applyStimulus(b, 1'b0, 1'b1);

        // Standalone dc_clear while idle.
        dc_clear = 1'b1;
        tick();
        dc_clear = 1'b0;
        prev_dc = 0;
        b = '0; b[0][0] = IW'(-9);
        applyStimulus(b, 1'b0, 1'b0);

        // Random blocks of varying density.
        for (int n = 0; n < 24; n++) begin
            applyStimulus(random_block(int'($urandom_range(0, 60))), ($urandom_range(0, 3) == 0), (n % 6 == 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during the AC scan aborts the block and clears the predictor.
        b = '0; b[0][0] = IW'(100); b[0][1] = IW'(5); b[1][0] = IW'(6); b[4][4] = IW'(3);
        q_block  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sym_ready = 1'b1;
        cyc = 0;
        while (!(sym_valid && !sym_is_dc) && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput("abort_reached_ac", sym_valid && !sym_is_dc, 1);
        sym_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_sym_valid", sym_valid, 0);
        checkOutput("abort_outputs", cur(), 0);
        checkOutput("abort_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        prev_dc = 0;
        tick();
        checkOutput("abort_ready_after_release", in_ready, 1);
        checkOutput("abort_no_symbols", sym_valid, 0);
        b = '0; b[0][0] = IW'(7);
        applyStimulus(b, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
